// File: rtl/hit_scorer_pkg.sv
// hit_scorer_pkg
//   Shared definitions for the hit scorer slice: target state encoding,
//   the register-file slot that receives the score, default timing
//   constants and a counter-width helper.
package hit_scorer_pkg;

    typedef enum logic {
        LIT  = 1'b0,
        DARK = 1'b1
    } state_e;

    localparam logic [4:0] SCORE_REG = 5'd30;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_LIT_CYCLES      = 100000000;
    localparam int unsigned DEF_DARK_CYCLES     = 50000000;
    localparam int unsigned DEF_PEND_W          = 3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer, counting debouncer and falling-edge detector
//   for an active-low push button.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   btn_n    in   raw asynchronous button, low = pressed
//   press    out  one-cycle pulse when the debounced level goes 1->0
module btn_debounce
    import hit_scorer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds how many consecutive samples already disagreed with
    // level_q; the disagreeing sample that would make it DEBOUNCE_CYCLES
    // flips the level instead of counting.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/hit_scorer.sv
// hit_scorer
//   Reaction game: a target LED is lit for up to LIT_CYCLES, then dark for
//   DARK_CYCLES. A debounced press while lit is a hit; hits accumulate in a
//   saturating pending counter that is injected into register 30 of the
//   processor register file on cycles the processor is not writing.
//   Optional feature macro: HIT_SCORER_MISS_EN (counts presses while dark).
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   btn_n       in   raw asynchronous button, low = pressed
//   cpu_rwe     in   processor register-file write enable this cycle
//   target_led  out  high while the target is lit
//   inj_we      out  register-file injection write enable (combinational)
//   inj_rd      out  injection destination register (always 30)
//   inj_data    out  pending hit count, zero-extended
//   miss_cnt    out  saturating miss count (0 when feature disabled)
module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LIT_CYCLES      = DEF_LIT_CYCLES,
    parameter int unsigned DARK_CYCLES     = DEF_DARK_CYCLES,
    parameter int unsigned PEND_W          = DEF_PEND_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_n,
    input  logic        cpu_rwe,
    output logic        target_led,
    output logic        inj_we,
    output logic [4:0]  inj_rd,
    output logic [31:0] inj_data,
    output logic [7:0]  miss_cnt
);

    localparam int unsigned TW = cnt_width((LIT_CYCLES > DARK_CYCLES) ? LIT_CYCLES : DARK_CYCLES);

    state_e              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                inj_prev_q;
    logic                press;
    logic                hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_n),
        .press   (press)
    );

    assign hit = press & (state_q == LIT);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        case (state_q)
            LIT: begin
                if (hit || (timer_q == TW'(LIT_CYCLES - 1))) begin
                    state_d = DARK;
                    timer_d = '0;
                end
            end
            DARK: begin
                if (timer_q == TW'(DARK_CYCLES - 1)) begin
                    state_d = LIT;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = LIT;
                timer_d = '0;
            end
        endcase
    end

    // Gated by reset_n so outputs show the reset values during the first
    // reset cycle, before the registers have been cleared.
    assign inj_we = reset_n & (pend_q != '0) & ~cpu_rwe & ~inj_prev_q;

    // An injection drains the counter; a hit in that same cycle is kept
    // as the new count so it is not lost.
    always_comb begin
        pend_d = pend_q;
        if (inj_we) begin
            pend_d = hit ? PEND_W'(1) : '0;
        end else if (hit && (pend_q != '1)) begin
            pend_d = pend_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= LIT;
            timer_q    <= '0;
            pend_q     <= '0;
            inj_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            inj_prev_q <= inj_we;
        end
    end

    assign target_led = ~reset_n | (state_q == LIT);
    assign inj_rd     = SCORE_REG;
    assign inj_data   = 32'(pend_q);

`ifdef HIT_SCORER_MISS_EN
    logic [7:0] miss_q, miss_d;

    always_comb begin
        miss_d = miss_q;
        if (press && (state_q == DARK) && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt = miss_q;
`else
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_hit_scorer.sv
module tb_hit_scorer;

    localparam int DB = 4;
    localparam int LC = 20;
    localparam int DC = 10;
`ifdef HIT_SCORER_MISS_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_n;
    logic        cpu_rwe;
    logic        target_led;
    logic        inj_we;
    logic [4:0]  inj_rd;
    logic [31:0] inj_data;
    logic [7:0]  miss_cnt;

    always #5 clk = ~clk;

    hit_scorer #(
        .DEBOUNCE_CYCLES(DB),
        .LIT_CYCLES     (LC),
        .DARK_CYCLES    (DC),
        .PEND_W         (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .cpu_rwe    (cpu_rwe),
        .target_led (target_led),
        .inj_we     (inj_we),
        .inj_rd     (inj_rd),
        .inj_data   (inj_data),
        .miss_cnt   (miss_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: button samples as a history, debounced level flips
    // when the last DB synchronized samples all disagree with it; phases
    // timed by absolute cycle of entry.
    int cyc = 0;
    bit m_lit;
    int m_t0;
    int m_pend;
    int m_miss;
    bit m_prev;
    bit m_lvl;
    bit m_press;
    bit bq[$];
    bit win[$];

    // Observations of the DUT for scenario-level checks.
    int inj_pulses;
    int inj_log[$];
    int inj_at[$];
    int falls;
    int led_hi;
    bit led_prev;
    int stepno = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lit   = 1'b1;
        m_t0    = cyc + 1;
        m_pend  = 0;
        m_miss  = 0;
        m_prev  = 1'b0;
        m_lvl   = 1'b1;
        m_press = 1'b0;
        bq      = '{1'b1, 1'b1};
        win.delete();
    endtask

    task automatic model_edge(input logic r, input logic b, input logic inj);
        bit used, hit, all_diff;
        int age;
        if (!r) begin
            model_reset();
        end else begin
            hit = m_press && m_lit;
            age = cyc - m_t0;
            if (m_press && !m_lit && m_miss < 255) m_miss++;
            if (m_lit) begin
                if (hit || age == LC - 1) begin
                    m_lit = 1'b0;
                    m_t0  = cyc + 1;
                end
            end else if (age == DC - 1) begin
                m_lit = 1'b1;
                m_t0  = cyc + 1;
            end
            if (inj) m_pend = hit ? 1 : 0;
            else if (hit && m_pend < 7) m_pend++;
            m_prev = inj;
            used = bq[0];
            void'(bq.pop_front());
            bq.push_back(b);
            win.push_back(used);
            if (win.size() > DB) void'(win.pop_front());
            m_press = 1'b0;
            if (win.size() == DB) begin
                all_diff = 1'b1;
                foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
                if (all_diff) begin
                    m_lvl = !m_lvl;
                    win.delete();
                    m_press = !m_lvl;
                end
            end
        end
        cyc++;
    endtask

    task automatic step(input logic r, input logic b, input logic w);
        logic e_led, e_inj;
        @(negedge clk);
        reset_n = r;
        btn_n   = b;
        cpu_rwe = w;
        #1;
        e_led = !r || m_lit;
        e_inj = r && (m_pend != 0) && !w && !m_prev;
        chk("target_led", 32'(target_led), 32'(e_led));
        chk("inj_we", 32'(inj_we), 32'(e_inj));
        chk("inj_rd", 32'(inj_rd), 32'd30);
        chk("inj_data", inj_data, 32'(m_pend));
        chk("miss_cnt", 32'(miss_cnt), MISS_EN ? 32'(m_miss) : 32'd0);
        if (inj_we === 1'b1) begin
            inj_pulses++;
            inj_log.push_back(int'(inj_data));
            inj_at.push_back(stepno);
        end
        if (led_prev && target_led === 1'b0) falls++;
        if (target_led === 1'b1) led_hi++;
        led_prev = (target_led === 1'b1);
        @(posedge clk);
        model_edge(r, b, e_inj);
        stepno++;
    endtask

    task automatic run(input int n, input logic b, input logic w);
        for (int i = 0; i < n; i++) step(1'b1, b, w);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear_logs();
        inj_pulses = 0;
        inj_log.delete();
        inj_at.delete();
        falls    = 0;
        led_hi   = 0;
        led_prev = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        btn_n   = 1'b1;
        cpu_rwe = 1'b0;
        model_reset();

        // Reset state and idle blink pattern.
        do_reset(3);
        chk("reset_inj_data", inj_data, 32'd0);
        chk("reset_led", 32'(target_led), 32'd1);
        clear_logs();
        run(30, 1'b1, 1'b0);
        chk("idle_lit_cycles", 32'(led_hi), 32'd20);
        run(30, 1'b1, 1'b0);
        chk("idle_lit_cycles_2", 32'(led_hi), 32'd40);
        chk("idle_no_inj", 32'(inj_pulses), 32'd0);

        // Held press during LIT: one hit, one injection of 1.
        do_reset(2);
        clear_logs();
        run(3, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0);
        run(20, 1'b1, 1'b0);
        chk("hit_led_falls", 32'(falls), 32'd1);
        chk("hit_inj_pulses", 32'(inj_pulses), 32'd1);
        chk("hit_inj_data", (inj_log.size() > 0) ? 32'(inj_log[0]) : 32'hDEAD, 32'd1);

        // Two-cycle glitch is filtered.
        do_reset(2);
        clear_logs();
        run(2, 1'b1, 1'b0);
        run(2, 1'b0, 1'b0);
        run(12, 1'b1, 1'b0);
        chk("glitch_falls", 32'(falls), 32'd0);
        chk("glitch_inj", 32'(inj_pulses), 32'd0);

        // Debounce boundary: 3 low samples rejected, 4 accepted.
        do_reset(2);
        clear_logs();
        run(3, 1'b0, 1'b0);
        run(8, 1'b1, 1'b0);
        chk("db3_falls", 32'(falls), 32'd0);
        run(4, 1'b0, 1'b0);
        run(10, 1'b1, 1'b0);
        chk("db4_falls", 32'(falls), 32'd1);
        chk("db4_inj", 32'(inj_pulses), 32'd1);

        // cpu_rwe blocks injection while three hits accumulate.
        do_reset(2);
        clear_logs();
        run(2, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run(8, 1'b0, 1'b1);
            run(12, 1'b1, 1'b1);
        end
        chk("rwe_blocked", 32'(inj_pulses), 32'd0);
        chk("rwe_pending3", inj_data, 32'd3);
        run(3, 1'b1, 1'b0);
        chk("rwe_release_pulses", 32'(inj_pulses), 32'd1);
        chk("rwe_release_data", (inj_log.size() > 0) ? 32'(inj_log[0]) : 32'hDEAD, 32'd3);

        // Hit coincides with an injection of 2.
        do_reset(2);
        clear_logs();
        run(2, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            run(8, 1'b0, 1'b1);
            run(12, 1'b1, 1'b1);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, (i < 6) ? 1'b1 : 1'b0);
        run(6, 1'b1, 1'b0);
        chk("coinc_pulses", 32'(inj_pulses), 32'd2);
        chk("coinc_first", (inj_log.size() > 0) ? 32'(inj_log[0]) : 32'hDEAD, 32'd2);
        chk("coinc_second", (inj_log.size() > 1) ? 32'(inj_log[1]) : 32'hDEAD, 32'd1);
        chk("coinc_gap", (inj_at.size() > 1) ? 32'(inj_at[1] - inj_at[0]) : 32'hDEAD, 32'd2);

        // Presses in DARK are misses, never hits.
        do_reset(2);
        clear_logs();
        run(20, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0);
        run(26, 1'b1, 1'b0);
        run(4, 1'b0, 1'b0);
        run(6, 1'b1, 1'b0);
        chk("miss_count", 32'(miss_cnt), MISS_EN ? 32'd2 : 32'd0);
        chk("miss_no_inj", 32'(inj_pulses), 32'd0);
        chk("miss_pending", inj_data, 32'd0);

        // Reset with a pending hit discards it.
        do_reset(2);
        run(2, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1);
        run(2, 1'b1, 1'b1);
        chk("pre_reset_pending", inj_data, 32'd1);
        do_reset(2);
        clear_logs();
        run(5, 1'b1, 1'b0);
        chk("post_reset_inj", 32'(inj_pulses), 32'd0);
        chk("post_reset_pending", inj_data, 32'd0);

        // Randomized segments against the reference model.
        do_reset(2);
        for (int s = 0; s < 60; s++) begin
            int   len;
            logic b, w, r;
            len = int'($urandom_range(1, 12));
            b   = 1'($urandom_range(0, 1));
            w   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 40) != 0);
            for (int i = 0; i < len; i++) step(r, b, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hit_scorer.md
HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples needed to accept a new button level.
REQ-002 Parameter LIT_CYCLES, default 100000000, maximum target-lit time in cycles.
REQ-003 Parameter DARK_CYCLES, default 50000000, target-dark time in cycles.
REQ-004 Parameter PEND_W, default 3, width of the pending-hit counter.
REQ-005 clk  in  1  single clock; all state on posedge clk.
REQ-006 reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-007 btn_n  in  1  raw asynchronous button, low = pressed.
REQ-008 cpu_rwe  in  1  processor register-file write enable for the current cycle.
REQ-009 target_led  out  1  high while the target is lit.
REQ-010 inj_we  out  1  register-file write-injection enable.
REQ-011 inj_rd  out  5  injection destination register, constant 30.
REQ-012 inj_data  out  32  injection data, pending hit count zero-extended.
REQ-013 miss_cnt  out  8  miss count (see Configuration).

Function
REQ-014 btn_n SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any agreeing sample restarts the count.
REQ-016 Press event SHALL be a one-cycle pulse on a debounced 1->0 transition; the 0->1 release produces no event.
REQ-017 Target FSM SHALL have states LIT and DARK, with one shared timer that clears on every state change.
REQ-018 LIT->DARK SHALL occur when the timer reaches LIT_CYCLES-1, or on a press event (a hit).
REQ-019 DARK->LIT SHALL occur when the timer reaches DARK_CYCLES-1; presses in DARK SHALL NOT change state.
REQ-020 target_led SHALL be high exactly in state LIT.
REQ-021 A hit SHALL increment the pending counter on the next clock edge; the counter saturates at 2^PEND_W-1.
REQ-022 inj_we SHALL be combinational: high when pending!=0, cpu_rwe==0, and inj_we was low in the previous cycle.
REQ-023 inj_we SHALL never be high in two consecutive cycles.
REQ-024 inj_rd SHALL always be 30; inj_data SHALL equal the registered pending value.
REQ-025 On a cycle with inj_we high, pending SHALL clear, or become 1 if a hit occurs in the same cycle.
REQ-026 While cpu_rwe is high, pending SHALL be held and accumulate hits; no hit is lost below saturation.

Reset
REQ-027 While reset_n is low, the block SHALL hold this state: LIT, timer 0, pending 0, miss_cnt 0, debounced level 1, synchronizer 1s, debounce counter 0, previous-inj flag 0.
REQ-028 Output values under reset SHALL be target_led=1 and inj_we=0.
REQ-029 Reset asserted mid-debounce or mid-injection SHALL discard all pending hits.

Configuration
REQ-030 With HIT_SCORER_MISS_EN defined, each press event in DARK SHALL increment miss_cnt, saturating at 255.
REQ-031 With HIT_SCORER_MISS_EN undefined, miss_cnt SHALL be constant 0 and no miss logic is synthesized.

Structure
REQ-032 The shared package hit_scorer_pkg SHALL hold: the state enum (LIT, DARK), SCORE_REG=5'd30, and the default timing constants.
REQ-033 Synchronizer, debouncer and edge detect SHALL form sub-module btn_debounce (ports clk, reset_n, btn_n, press); hit_scorer instantiates it once.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, LIT_CYCLES=20, DARK_CYCLES=10.
REQ-034 Reset, then idle -> target_led is high for 20 cycles, low for 10, and repeats; inj_we stays 0.
REQ-035 Press held 8 cycles during LIT, cpu_rwe=0 -> target_led falls once; one inj_we pulse with inj_rd=30, inj_data=1.
REQ-036 Glitch of btn_n low for 2 cycles -> no press event, no state change, no injection.
REQ-037 cpu_rwe held high while 3 hits land across successive LIT periods -> no inj_we; on cpu_rwe low, a single pulse with inj_data=3.
REQ-038 Hit on the same cycle as an injection of 2 -> inj_data=2 that cycle, then pending=1, then after a one-cycle gap a pulse with inj_data=1.
REQ-039 HIT_SCORER_MISS_EN defined, 2 presses in DARK -> miss_cnt=2, target_led stays low, pending stays 0; undefined -> miss_cnt=0.
